// File: rtl/mxv_seq_ctrl_if.sv
// Handshake bundle between the matrix-vector sequencer and its surroundings
// (command FSM, FIFOs A/B, MAC datapath, UART transmitter).
interface mxv_seq_ctrl_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned NW = 4
);

  // command / status-in side
  logic            start;
  logic            clear;
  logic [NW-1:0]   n;
  logic            fifo_a_empty;
  logic            fifo_b_empty;
  logic [2*DW-1:0] res;
  logic            tx_done;

  // sequencer-driven side
  logic            pop_a;
  logic            pop_b;
  logic            load_vec;
  logic [NW-1:0]   vec_idx;
  logic            mac_clr;
  logic            mac_en;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            busy;
  logic            ready;
  logic            err;

  // Command/datapath side: drives requests and flags, observes sequencer outputs
  modport master (
    output start, clear, n, fifo_a_empty, fifo_b_empty, res, tx_done,
    input  pop_a, pop_b, load_vec, vec_idx, mac_clr, mac_en,
           tx_start, tx_data, busy, ready, err
  );

  // Sequencer side
  modport slave (
    input  start, clear, n, fifo_a_empty, fifo_b_empty, res, tx_done,
    output pop_a, pop_b, load_vec, vec_idx, mac_clr, mac_en,
           tx_start, tx_data, busy, ready, err
  );

endinterface

// File: rtl/mxv_seq_ctrl.sv
// Matrix-vector sequencer: loads N vector elements from FIFO B, runs N MAC
// rows over FIFO A and streams each 16-bit row result as two UART bytes.
// Optional macro SEQ_CHECKSUM_EN appends an XOR checksum byte per run.
module mxv_seq_ctrl #(
  parameter int unsigned DW      = 8,
  parameter int unsigned NW      = 4,
  parameter int unsigned MAX_N   = 8,
  parameter int unsigned MAC_LAT = 2
) (
  input logic           clk,
  input logic           rst,
  mxv_seq_ctrl_if.slave bus
);

  localparam int unsigned RW    = 2 * DW;
  localparam int unsigned DLY_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD_B = 4'd1,
    S_CLR    = 4'd2,
    S_MAC    = 4'd3,
    S_DRAIN  = 4'd4,
    S_SEND_H = 4'd5,
    S_WAIT_H = 4'd6,
    S_SEND_L = 4'd7,
    S_WAIT_L = 4'd8,
    S_DONE   = 4'd9
`ifdef SEQ_CHECKSUM_EN
    ,
    S_SEND_C = 4'd10,
    S_WAIT_C = 4'd11
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [NW-1:0]    n_q;
  logic [NW-1:0]    col_cnt_q;
  logic [NW-1:0]    row_cnt_q;
  logic [DLY_W-1:0] dly_cnt_q;
  logic [RW-1:0]    res_q;
  logic             err_q;

  logic             n_legal_c;
  logic             accept_c;
  logic [NW-1:0]    n_m1_c;
  logic             col_last_c;
  logic             row_last_c;
  logic             dly_last_c;
  logic             b_pop_c;
  logic             a_pop_c;
  logic [DW-1:0]    byte_h_c;
  logic [DW-1:0]    byte_l_c;

  // Shared decode used by both the FSM and the counters
  assign n_legal_c  = (bus.n != '0) && (32'(bus.n) <= MAX_N);
  assign accept_c   = (state_q == S_IDLE) && bus.start && n_legal_c && !bus.clear;
  assign n_m1_c     = n_q - NW'(1);
  assign col_last_c = (col_cnt_q == n_m1_c);
  assign row_last_c = (row_cnt_q == n_m1_c);
  assign dly_last_c = (dly_cnt_q == DLY_W'(MAC_LAT - 1));
  assign b_pop_c    = (state_q == S_LOAD_B) && !bus.fifo_b_empty && !bus.clear;
  assign a_pop_c    = (state_q == S_MAC) && !bus.fifo_a_empty && !bus.clear;
  assign byte_h_c   = res_q[RW-1:DW];
  assign byte_l_c   = res_q[DW-1:0];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides everything
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (bus.start && n_legal_c) state_d = S_LOAD_B;
        S_LOAD_B: if (b_pop_c && col_last_c) state_d = S_CLR;
        S_CLR:    state_d = S_MAC;
        S_MAC:    if (a_pop_c && col_last_c) state_d = S_DRAIN;
        S_DRAIN:  if (dly_last_c) state_d = S_SEND_H;
        S_SEND_H: state_d = S_WAIT_H;
        S_WAIT_H: if (bus.tx_done) state_d = S_SEND_L;
        S_SEND_L: state_d = S_WAIT_L;
        S_WAIT_L: begin
          if (bus.tx_done) begin
            if (row_last_c) begin
`ifdef SEQ_CHECKSUM_EN
              state_d = S_SEND_C;
`else
              state_d = S_DONE;
`endif
            end else begin
              state_d = S_CLR;
            end
          end
        end
`ifdef SEQ_CHECKSUM_EN
        S_SEND_C: state_d = S_WAIT_C;
        S_WAIT_C: if (bus.tx_done) state_d = S_DONE;
`endif
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Latched N, column/row/drain counters, result capture and error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q       <= '0;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      dly_cnt_q <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
    end else if (bus.clear) begin
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      dly_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (n_legal_c) begin
              n_q       <= bus.n;
              err_q     <= 1'b0;
              col_cnt_q <= '0;
              row_cnt_q <= '0;
              dly_cnt_q <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_LOAD_B: begin
          if (b_pop_c) col_cnt_q <= col_last_c ? '0 : col_cnt_q + NW'(1);
        end
        S_CLR: begin
          col_cnt_q <= '0;
          dly_cnt_q <= '0;
        end
        S_MAC: begin
          if (a_pop_c) col_cnt_q <= col_last_c ? '0 : col_cnt_q + NW'(1);
        end
        S_DRAIN: begin
          if (dly_last_c) begin
            res_q     <= bus.res;
            dly_cnt_q <= '0;
          end else begin
            dly_cnt_q <= dly_cnt_q + DLY_W'(1);
          end
        end
        S_WAIT_L: begin
          if (bus.tx_done && !row_last_c) row_cnt_q <= row_cnt_q + NW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_CHECKSUM_EN
  logic [DW-1:0] chk_q;

  // Running XOR of every result byte sent in the current run
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_q <= '0;
    end else if (bus.clear || accept_c) begin
      chk_q <= '0;
    end else if (state_q == S_SEND_H) begin
      chk_q <= chk_q ^ byte_h_c;
    end else if (state_q == S_SEND_L) begin
      chk_q <= chk_q ^ byte_l_c;
    end
  end
`endif

  // Output decode; pop/MAC/transmit strobes are suppressed during clear
  always_comb begin
    bus.pop_a    = 1'b0;
    bus.pop_b    = 1'b0;
    bus.load_vec = 1'b0;
    bus.mac_clr  = 1'b0;
    bus.mac_en   = 1'b0;
    bus.tx_start = 1'b0;
    bus.tx_data  = '0;
    bus.ready    = 1'b0;
    bus.busy     = (state_q != S_IDLE);
    bus.vec_idx  = col_cnt_q;
    bus.err      = err_q;
    case (state_q)
      S_LOAD_B: begin
        bus.pop_b    = b_pop_c;
        bus.load_vec = b_pop_c;
      end
      S_CLR:    bus.mac_clr = !bus.clear;
      S_MAC: begin
        bus.pop_a  = a_pop_c;
        bus.mac_en = a_pop_c;
      end
      S_SEND_H: begin
        bus.tx_start = !bus.clear;
        bus.tx_data  = byte_h_c;
      end
      S_WAIT_H: bus.tx_data = byte_h_c;
      S_SEND_L: begin
        bus.tx_start = !bus.clear;
        bus.tx_data  = byte_l_c;
      end
      S_WAIT_L: bus.tx_data = byte_l_c;
`ifdef SEQ_CHECKSUM_EN
      S_SEND_C: begin
        bus.tx_start = !bus.clear;
        bus.tx_data  = chk_q;
      end
      S_WAIT_C: bus.tx_data = chk_q;
`endif
      S_DONE:   bus.ready = 1'b1;
      default: ;
    endcase
  end

  logic unused_accept;
  assign unused_accept = accept_c;

endmodule

// File: tb/tb_mxv_seq_ctrl.sv
// Scoreboard bench for mxv_seq_ctrl: stimulus pushes expected bytes and
// vector indices, a negedge monitor pops and compares as the DUT emits them.
module tb_mxv_seq_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned NW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mxv_seq_ctrl_if #(.DW(DW), .NW(NW)) ifc ();

  mxv_seq_ctrl #(.DW(DW), .NW(NW), .MAX_N(8), .MAC_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  exp_bytes[$];
  logic [3:0]  exp_av[$];
  logic [3:0]  exp_bv[$];
  logic [15:0] res_vals[$];

  int cnt_pa  = 0;
  int cnt_pb  = 0;
  int cnt_rdy = 0;
  int cnt_tx  = 0;
  int b_pa, b_pb, b_rdy, b_tx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic unexp(input string name, input logic [31:0] act);
    n_chk++;
    $display("FAIL %s: unexpected event, value 0x%0h, expected none", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue up the full expected response of one run
  task automatic prep(input int n, input logic [15:0] r0, input logic [15:0] r1,
                      input logic [15:0] r2);
    logic [15:0] rv[3];
    logic [7:0]  x;
    rv = '{r0, r1, r2};
    x  = 8'h00;
    b_pa = cnt_pa; b_pb = cnt_pb; b_rdy = cnt_rdy; b_tx = cnt_tx;
    for (int i = 0; i < n; i++) exp_bv.push_back(4'(i));
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) exp_av.push_back(4'(c));
      res_vals.push_back(rv[r]);
      exp_bytes.push_back(rv[r][15:8]);
      exp_bytes.push_back(rv[r][7:0]);
      x = x ^ rv[r][15:8] ^ rv[r][7:0];
    end
`ifdef SEQ_CHECKSUM_EN
    if (n > 0) exp_bytes.push_back(x);
`endif
  endtask

  task automatic do_start(input int n);
    ifc.n     = 4'(n);
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int k;
    k = 0;
    while (!ifc.ready && k < budget) begin
      tick();
      k++;
    end
    chk("ready_seen", 32'(ifc.ready), 32'd1);
    tick();
    tick();
  endtask

  task automatic post(input string tag, input int n);
    chk({tag, "_busy_after"},  32'(ifc.busy), 32'd0);
    chk({tag, "_pop_b_count"}, 32'(cnt_pb - b_pb), 32'(n));
    chk({tag, "_pop_a_count"}, 32'(cnt_pa - b_pa), 32'(n * n));
    chk({tag, "_ready_count"}, 32'(cnt_rdy - b_rdy), 32'd1);
    chk({tag, "_bytes_left"},  32'(exp_bytes.size()), 32'd0);
    chk({tag, "_macidx_left"}, 32'(exp_av.size()), 32'd0);
  endtask

  // Monitor: compare every emitted byte / index against the scoreboard
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (ifc.tx_start) begin
        cnt_tx++;
        if (exp_bytes.size() == 0) unexp("tx_byte", 32'(ifc.tx_data));
        else chk("tx_byte", 32'(ifc.tx_data), 32'(exp_bytes.pop_front()));
      end
      if (ifc.mac_en) begin
        if (exp_av.size() == 0) unexp("mac_vidx", 32'(ifc.vec_idx));
        else chk("mac_vidx", 32'(ifc.vec_idx), 32'(exp_av.pop_front()));
      end
      if (ifc.load_vec) begin
        if (exp_bv.size() == 0) unexp("load_vidx", 32'(ifc.vec_idx));
        else chk("load_vidx", 32'(ifc.vec_idx), 32'(exp_bv.pop_front()));
      end
      if (ifc.fifo_a_empty) begin
        chk("stall_pop_a",  32'(ifc.pop_a), 32'd0);
        chk("stall_mac_en", 32'(ifc.mac_en), 32'd0);
      end
      if (ifc.pop_a) cnt_pa++;
      if (ifc.pop_b) cnt_pb++;
      if (ifc.ready) cnt_rdy++;
    end
  end

  // UART model: byte-complete pulse one cycle after each tx_start
  initial forever begin
    @(negedge clk);
    if (ifc.tx_start) begin
      @(posedge clk);
      #1 ifc.tx_done = 1'b1;
      @(posedge clk);
      #1 ifc.tx_done = 1'b0;
    end
  end

  // MAC model: each accumulator clear starts the next queued row result
  initial forever begin
    @(negedge clk);
    if (ifc.mac_clr && res_vals.size() > 0) ifc.res = res_vals.pop_front();
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    ifc.start        = 1'b0;
    ifc.clear        = 1'b0;
    ifc.n            = '0;
    ifc.fifo_a_empty = 1'b0;
    ifc.fifo_b_empty = 1'b0;
    ifc.res          = '0;
    ifc.tx_done      = 1'b0;
    rst              = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",     32'(ifc.busy), 32'd0);
    chk("rst_err",      32'(ifc.err), 32'd0);
    chk("rst_pop_a",    32'(ifc.pop_a), 32'd0);
    chk("rst_pop_b",    32'(ifc.pop_b), 32'd0);
    chk("rst_load_vec", 32'(ifc.load_vec), 32'd0);
    chk("rst_mac_clr",  32'(ifc.mac_clr), 32'd0);
    chk("rst_mac_en",   32'(ifc.mac_en), 32'd0);
    chk("rst_tx_start", 32'(ifc.tx_start), 32'd0);
    chk("rst_tx_data",  32'(ifc.tx_data), 32'd0);
    chk("rst_ready",    32'(ifc.ready), 32'd0);
    chk("rst_vec_idx",  32'(ifc.vec_idx), 32'd0);
    rst = 1'b1;
    tick();

    // N=2 basic run: bytes 12 34 00 AB
    prep(2, 16'h1234, 16'h00AB, 16'h0000);
    do_start(2);
    chk("t1_busy_start", 32'(ifc.busy), 32'd1);
    wait_ready(200);
    post("t1", 2);

    // Illegal N values set err without any activity
    prep(0, 16'h0, 16'h0, 16'h0);
    do_start(0);
    tick(); tick();
    chk("t2_err_n0",  32'(ifc.err), 32'd1);
    chk("t2_busy_n0", 32'(ifc.busy), 32'd0);
    do_start(9);
    tick(); tick();
    chk("t2_err_n9",  32'(ifc.err), 32'd1);
    chk("t2_busy_n9", 32'(ifc.busy), 32'd0);
    chk("t2_no_pop_b", 32'(cnt_pb - b_pb), 32'd0);
    chk("t2_no_pop_a", 32'(cnt_pa - b_pa), 32'd0);
    prep(1, 16'hBEEF, 16'h0, 16'h0);
    do_start(1);
    chk("t2_err_cleared", 32'(ifc.err), 32'd0);
    chk("t2_busy_n1",     32'(ifc.busy), 32'd1);
    wait_ready(200);
    post("t2", 1);

    // N=3 with FIFO A empty for 5 cycles in row 1
    prep(3, 16'h0102, 16'h0304, 16'h0506);
    do_start(3);
    k = 0;
    while ((cnt_pa - b_pa) < 4 && k < 200) begin
      tick();
      k++;
    end
    chk("t3_stall_reached", 32'(cnt_pa - b_pa), 32'd4);
    ifc.fifo_a_empty = 1'b1;
    repeat (5) tick();
    ifc.fifo_a_empty = 1'b0;
    chk("t3_pops_in_stall", 32'(cnt_pa - b_pa), 32'd4);
    wait_ready(300);
    post("t3", 3);

    // clear during WAIT_H of row 0 aborts the run
    prep(0, 16'h0, 16'h0, 16'h0);
    exp_bv.push_back(4'd0); exp_bv.push_back(4'd1);
    exp_av.push_back(4'd0); exp_av.push_back(4'd1);
    res_vals.push_back(16'h1357);
    exp_bytes.push_back(8'h13);
    do_start(2);
    k = 0;
    while (!ifc.tx_start && k < 200) begin
      tick();
      k++;
    end
    chk("t4_send_h_reached", 32'(ifc.tx_start), 32'd1);
    tick();
    chk("t4_wait_h_data", 32'(ifc.tx_data), 32'h13);
    ifc.clear = 1'b1;
    tick();
    ifc.clear = 1'b0;
    chk("t4_busy_cleared", 32'(ifc.busy), 32'd0);
    chk("t4_err_cleared",  32'(ifc.err), 32'd0);
    repeat (20) tick();
    chk("t4_tx_count",    32'(cnt_tx - b_tx), 32'd1);
    chk("t4_no_ready",    32'(cnt_rdy - b_rdy), 32'd0);
    chk("t4_bytes_left",  32'(exp_bytes.size()), 32'd0);
    prep(2, 16'hCAFE, 16'h0F0F, 16'h0000);
    do_start(2);
    wait_ready(200);
    post("t4b", 2);

    // start with n=5 during MAC is ignored
    prep(2, 16'h8001, 16'h7FFE, 16'h0000);
    do_start(2);
    k = 0;
    while (!ifc.mac_en && k < 200) begin
      tick();
      k++;
    end
    chk("t5_mac_reached", 32'(ifc.mac_en), 32'd1);
    ifc.n     = 4'd5;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    chk("t5_busy_kept", 32'(ifc.busy), 32'd1);
    wait_ready(200);
    post("t5", 2);
    chk("t5_tx_count", 32'(cnt_tx - b_tx),
`ifdef SEQ_CHECKSUM_EN
        32'd5);
`else
        32'd4);
`endif

    // N=1 run, res 5A3C (checksum byte 66 when enabled)
    prep(1, 16'h5A3C, 16'h0, 16'h0);
`ifdef SEQ_CHECKSUM_EN
    chk("t6_checksum_model", 32'(exp_bytes[2]), 32'h66);
`endif
    do_start(1);
    wait_ready(200);
    post("t6", 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mxv_seq_ctrl.md
Name: mxv_seq_ctrl

Overview:
- Sequencer for the matrix-vector processor datapath.
- On a start command from the UART command FSM it does the following, in order:
  - drains N vector elements from FIFO B into the processor vector registers;
  - runs N multiply-accumulate (MAC) rows, each consuming N elements from FIFO A;
  - streams each 16-bit row result to the UART transmitter as two bytes, high byte first.
- It owns all pop, MAC and transmit handshakes, so the command FSM only issues start and clear.

Parameters:
- DW, 8, UART byte / element width.
- NW, 4, width of the N size field.
- MAX_N, 8, largest legal N; N = 0 or N > MAX_N is rejected.
- MAC_LAT, 2, cycles from the last mac_en until res is valid.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, reset asynchronous and active-low.
- start  in  1  one-cycle compute request.
- clear  in  1  synchronous abort to IDLE.
- n  in  NW  matrix dimension, sampled when start is accepted.
- fifo_a_empty  in  1  FIFO A empty flag.
- fifo_b_empty  in  1  FIFO B empty flag.
- res  in  2*DW  current row accumulator.
- tx_done  in  1  UART TX byte-complete pulse.
- pop_a  out  1  pop FIFO A.
- pop_b  out  1  pop FIFO B.
- load_vec  out  1  write vector register vec_idx.
- vec_idx  out  NW  vector / column index.
- mac_clr  out  1  clear accumulator.
- mac_en  out  1  accumulate current A element × vector[vec_idx].
- tx_start  out  1  one-cycle transmit request.
- tx_data  out  DW  byte to send; stable from tx_start until tx_done.
- busy  out  1  high in every state except IDLE.
- ready  out  1  one-cycle pulse when the last byte has been sent.
- err  out  1  sticky illegal-N flag; cleared by the next legal start or by clear.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, latched N 0.
- State machine: IDLE, LOAD_B, CLR, MAC, DRAIN, SEND_H, WAIT_H, SEND_L, WAIT_L, DONE.
- IDLE:
  - start with 1 ≤ n ≤ MAX_N: latch N, clear err, go to LOAD_B next cycle.
  - start with illegal n: set err, stay in IDLE.
- LOAD_B:
  - pop_b = load_vec = !fifo_b_empty (combinational); vec_idx = col_cnt.
  - col_cnt increments on each pop; an empty FIFO stalls with no pop and no count.
  - On the Nth pop, go to CLR.
- CLR: mac_clr for one cycle, col_cnt = 0, then MAC.
- MAC:
  - pop_a = mac_en = !fifo_a_empty; vec_idx = col_cnt; empty FIFO stalls.
  - On the Nth pop, go to DRAIN.
- DRAIN: wait exactly MAC_LAT cycles, register res into res_q, then SEND_H.
- SEND_H: tx_start pulse, tx_data = res_q[15:8], then WAIT_H.
- WAIT_H: hold until tx_done, then SEND_L.
- SEND_L: tx_start pulse, tx_data = res_q[7:0], then WAIT_L.
- WAIT_L:
  - On tx_done, if row_cnt == N−1 go to DONE; otherwise increment row_cnt and go to CLR.
- DONE: ready = 1 for one cycle, then IDLE.
- Minimum latency per row, with no stalls and tx_done arriving the cycle after tx_start: 1 + N + MAC_LAT + 4 cycles.
- start while busy is ignored; n is never re-sampled mid-operation.
- clear:
  - In any state it returns to IDLE next cycle: counters 0, tx_start/pop/mac outputs deasserted that same cycle, err cleared.
  - clear has priority over start in the same cycle.
- tx_done seen outside WAIT_H/WAIT_L is ignored.
- A tx_done in the same cycle as tx_start is not accepted; the controller waits for the next one.
- Counters are NW bits wide; the compare is against the latched N, so no wrap-around can occur.
- Async reset mid-operation aborts immediately; no partial byte is re-sent.

Optional Feature:
- Macro: SEQ_CHECKSUM_EN.
- With the macro defined:
  - Add states SEND_C and WAIT_C between the final WAIT_L and DONE.
  - tx_data = XOR of all 2N bytes sent in this run.
  - The checksum register clears on start acceptance and on clear.
  - ready pulses only after the checksum byte's tx_done.
- Without the macro: exactly 2N bytes per run; no checksum logic is present.

Test Plan:
- N=2, FIFOs pre-filled, res model returns 0x1234 then 0x00AB, tx_done one cycle after each tx_start:
  - 2 pop_b and 4 pop_a, with vec_idx 0,1,0,1 during MAC;
  - tx bytes 0x12, 0x34, 0x00, 0xAB;
  - one ready pulse; busy low afterwards.
- start with n=0, then n=9 → err=1, no pops, busy stays 0. Then start with n=1 → err cleared, 1 pop_b, 1 pop_a, 2 bytes sent.
- N=3, with fifo_a_empty forced high for 5 cycles in the middle of row 1 → mac_en/pop_a held low during the stall; exactly 3 pops per row; byte order unchanged.
- clear asserted in WAIT_H of row 0 (N=2) → IDLE next cycle, no further tx_start, no ready. A following start runs a full clean sequence.
- start pulsed during MAC with n=5 while the active N is 2 → ignored; the run completes with 4 bytes.
- With SEQ_CHECKSUM_EN, N=1, res=0x5A3C → bytes 0x5A, 0x3C, then 0x66; ready pulses after the third tx_done.
